// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load formatting, variable-latency load stall
// with optional timeout. Define WB_RETIRE_CNT_EN to add the 64-bit instret counter.
module wb_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_mem,
  input  logic [4:0]  rd_mem,
  input  logic        reg_write_mem,
  input  logic [1:0]  reg_src_mem,
  input  logic        mem_read_mem,
  input  logic [2:0]  load_type_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] pc_plus4_mem,
  input  logic [31:0] imm_mem,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        reg_write_in,
  output logic [4:0]  rd_wb,
  output logic [31:0] reg_write_data_wb,
  output logic        wb_stall,
  output logic        retire,
  output logic        load_err
`ifdef WB_RETIRE_CNT_EN
  ,output logic [63:0] instret
`endif
);

  typedef enum logic {S_RUN, S_WAIT} state_e;

  localparam logic [31:0] TO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  logic        valid_q, reg_write_q, mem_read_q;
  logic [4:0]  rd_q;
  logic [1:0]  reg_src_q;
  logic [2:0]  load_type_q;
  logic [31:0] alu_q, pc4_q, imm_q;
  state_e      state_q;
  logic [31:0] cnt_q;

  logic        pending, timeout_hit, complete;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt, ld_data;

  // The counter already holds 1 when WAIT is entered, so it equals the number
  // of stalled cycles so far; TIMEOUT=1 therefore times out in the RUN cycle.
  assign pending     = valid_q && mem_read_q;
  assign timeout_hit = (TIMEOUT > 0) && pending && !dmem_rvalid && (cnt_q == TO_LAST);
  assign wb_stall    = pending && !dmem_rvalid && !timeout_hit;
  assign complete    = valid_q && !wb_stall;

  assign retire       = complete;
  assign reg_write_in = complete && reg_write_q && (rd_q != 5'd0);
  assign load_err     = timeout_hit;
  assign rd_wb        = rd_q;

  always_comb begin
    ld_byte = dmem_rdata[8*alu_q[1:0] +: 8];
    ld_half = alu_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (load_type_q)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = dmem_rdata;
    endcase
    ld_data = timeout_hit ? 32'd0 : ld_fmt;
  end

  always_comb begin
    case (reg_src_q)
      2'b00:   reg_write_data_wb = alu_q;
      2'b01:   reg_write_data_wb = ld_data;
      2'b10:   reg_write_data_wb = pc4_q;
      default: reg_write_data_wb = imm_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      rd_q        <= '0;
      reg_src_q   <= '0;
      load_type_q <= '0;
      alu_q       <= '0;
      pc4_q       <= '0;
      imm_q       <= '0;
    end else if (!wb_stall) begin
      valid_q     <= valid_mem;
      reg_write_q <= reg_write_mem;
      mem_read_q  <= mem_read_mem;
      rd_q        <= rd_mem;
      reg_src_q   <= reg_src_mem;
      load_type_q <= load_type_mem;
      alu_q       <= alu_result_mem;
      pc4_q       <= pc_plus4_mem;
      imm_q       <= imm_mem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_RUN: if (wb_stall) begin
          state_q <= S_WAIT;
          cnt_q   <= 32'd1;
        end
        S_WAIT: if (wb_stall) begin
          cnt_q <= cnt_q + 32'd1;
        end else begin
          state_q <= S_RUN;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= S_RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + 64'd1;
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage (TIMEOUT=4): expected write-backs are queued as
// instructions are driven and matched against each retire pulse.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_mem, reg_write_mem, mem_read_mem, dmem_rvalid;
  logic [4:0]  rd_mem;
  logic [1:0]  reg_src_mem;
  logic [2:0]  load_type_mem;
  logic [31:0] alu_result_mem, pc_plus4_mem, imm_mem, dmem_rdata;
  logic        reg_write_in, wb_stall, retire, load_err;
  logic [4:0]  rd_wb;
  logic [31:0] reg_write_data_wb;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] instret;
`endif

  wb_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_mem(valid_mem), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
    .reg_src_mem(reg_src_mem), .mem_read_mem(mem_read_mem), .load_type_mem(load_type_mem),
    .alu_result_mem(alu_result_mem), .pc_plus4_mem(pc_plus4_mem), .imm_mem(imm_mem),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .reg_write_in(reg_write_in), .rd_wb(rd_wb), .reg_write_data_wb(reg_write_data_wb),
    .wb_stall(wb_stall), .retire(retire), .load_err(load_err)
`ifdef WB_RETIRE_CNT_EN
    , .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one MEM-stage entry; valid real instructions get their expected result queued.
  task automatic drive(input logic v, input logic [4:0] rd, input logic we, input logic [1:0] src,
                       input logic mr, input logic [2:0] lt, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [31:0] imm,
                       input logic [31:0] exp_data, input logic exp_err, input logic track);
    valid_mem = v; rd_mem = rd; reg_write_mem = we; reg_src_mem = src;
    mem_read_mem = mr; load_type_mem = lt; alu_result_mem = alu;
    pc_plus4_mem = pc4; imm_mem = imm;
    if (v && track) sb.push_back('{rd: rd, we: we && (rd != 5'd0), data: exp_data, err: exp_err});
  endtask

  task automatic bubble();
    drive(1'b0, 5'd31, 1'b1, 2'b01, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic cyc(input logic exp_stall);
    @(negedge clk);
    chk("wb_stall", wb_stall, exp_stall);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_we"},     reg_write_in, 1'b0);
    chk({tag, "_rd"},     rd_wb, 5'd0);
    chk({tag, "_data"},   reg_write_data_wb, 32'd0);
    chk({tag, "_stall"},  wb_stall, 1'b0);
    chk({tag, "_retire"}, retire, 1'b0);
    chk({tag, "_err"},    load_err, 1'b0);
  endtask

  // Retire monitor: every retire must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (retire) begin
        if (sb.size() == 0) chk("sb_underflow", 1'b1, 1'b0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("wb_rd",   rd_wb, e.rd);
          chk("wb_we",   reg_write_in, e.we);
          chk("wb_data", reg_write_data_wb, e.data);
          chk("wb_err",  load_err, e.err);
        end
      end else if (reg_write_in || load_err) begin
        chk("spurious_write_or_err", {reg_write_in, load_err}, 2'b00);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    dmem_rvalid = 1'b0; dmem_rdata = 32'hDEAD_0000;
    drive(1'b1, 5'd9, 1'b1, 2'b11, 1'b0, 3'b0, 32'h77, 32'h88, 32'h99, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk_zero_outputs("in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    bubble();
    @(negedge clk);
    chk_zero_outputs("after_reset");
    @(posedge clk); #1;

    // ALU write, then rd=0 write from pc_plus4
    drive(1'b1, 5'd5, 1'b1, 2'b00, 1'b0, 3'b0, 32'h1234, 32'h4, 32'h0, 32'h1234, 1'b0, 1'b1);
    cyc(1'b0);
    drive(1'b1, 5'd0, 1'b1, 2'b10, 1'b0, 3'b0, 32'h5, 32'h40, 32'h0, 32'h40, 1'b0, 1'b1);
    cyc(1'b0);
    // LB off=2, data arrives on the 3rd WB cycle; following ALU op held upstream
    drive(1'b1, 5'd7, 1'b1, 2'b01, 1'b1, 3'b000, 32'h0000_0102, 32'h0, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b1);
    cyc(1'b0);
    drive(1'b1, 5'd9, 1'b1, 2'b00, 1'b0, 3'b0, 32'h55, 32'h0, 32'h0, 32'h55, 1'b0, 1'b1);
    cyc(1'b1);
    cyc(1'b1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0080_0000;
    cyc(1'b0);
    // LHU / LH at off=2 with zero-latency rvalid
    dmem_rvalid = 1'b0;
    drive(1'b1, 5'd10, 1'b1, 2'b01, 1'b1, 3'b101, 32'h2, 32'h0, 32'h0, 32'h0000_BEEF, 1'b0, 1'b1);
    cyc(1'b0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_0000;
    drive(1'b1, 5'd11, 1'b1, 2'b01, 1'b1, 3'b001, 32'h2, 32'h0, 32'h0, 32'hFFFF_BEEF, 1'b0, 1'b1);
    cyc(1'b0);
    bubble();
    cyc(1'b0);
    // LBU at off=3 (bubble in WB sees a stray rvalid)
    dmem_rdata = 32'hA500_0000;
    drive(1'b1, 5'd13, 1'b1, 2'b01, 1'b1, 3'b100, 32'h3, 32'h0, 32'h0, 32'h0000_00A5, 1'b0, 1'b1);
    cyc(1'b0);
    // Timeout load: 3 stall cycles, then data 0 with load_err
    drive(1'b1, 5'd14, 1'b1, 2'b01, 1'b1, 3'b010, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    cyc(1'b0);
    dmem_rvalid = 1'b0;
    bubble();
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    cyc(1'b0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
    cyc(1'b0);
    // LUI path, then LW with one stall cycle
    dmem_rvalid = 1'b0;
    drive(1'b1, 5'd3, 1'b1, 2'b11, 1'b0, 3'b0, 32'h0, 32'h0, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 1'b1);
    cyc(1'b0);
    drive(1'b1, 5'd15, 1'b1, 2'b01, 1'b1, 3'b010, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    cyc(1'b0);
    bubble();
    cyc(1'b1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    cyc(1'b0);
    // Reset asserted while in WAIT: nothing retires
    dmem_rvalid = 1'b0;
    drive(1'b1, 5'd16, 1'b1, 2'b01, 1'b1, 3'b010, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0);
    bubble();
    cyc(1'b1);
    cyc(1'b1);
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_wait_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h2222_2222;
    cyc(1'b0);
`ifdef WB_RETIRE_CNT_EN
    chk("instret_reset", instret, 64'd0);
`endif
    dmem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(20 + i), 1'b1, 2'b00, 1'b0, 3'b0, 32'(i * 7), 32'h0, 32'h0, 32'(i * 7), 1'b0, 1'b1);
      cyc(1'b0);
    end
    bubble();
    cyc(1'b0);
`ifdef WB_RETIRE_CNT_EN
    chk("instret_3", instret, 64'd3);
`endif
    cyc(1'b0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back end of the pipeline; drives the register-file write port and WB forwarding data that the decode stage consumes (reg_write_in, rd_wb, reg_write_data_wb).
- Holds the MEM/WB pipeline register, formats load data from a variable-latency data memory, and selects the write-back source.
- Stalls the whole pipeline while a load waits for its data.

Parameters:
- TIMEOUT, 16, cycles a load may wait for dmem_rvalid before being forced to complete; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- valid_mem  input  1  MEM stage holds a real instruction (0 = bubble)
- rd_mem  input  5  destination register
- reg_write_mem  input  1  instruction writes rd
- reg_src_mem  input  2  write-back source: 00 ALU, 01 load, 10 pc_plus4, 11 imm
- mem_read_mem  input  1  instruction is a load
- load_type_mem  input  3  funct3 load encoding
- alu_result_mem  input  32  ALU result; bits [1:0] are the load byte offset
- pc_plus4_mem  input  32  link value
- imm_mem  input  32  immediate (LUI path)
- dmem_rvalid  input  1  load data valid this cycle
- dmem_rdata  input  32  raw aligned word from data memory
- reg_write_in  output  1  register-file write enable to decode
- rd_wb  output  5  register-file write address
- reg_write_data_wb  output  32  register-file write data / WB forward value
- wb_stall  output  1  freeze all upstream stages
- retire  output  1  one-cycle pulse per completed valid instruction
- load_err  output  1  one-cycle pulse when a load completes by timeout

Behaviour:
- Reset (async, rst_n=0): WB register cleared (valid=0), FSM=RUN, wait counter=0. All outputs 0 during reset and in the first cycle after it.
- Advance: on a rising clk with wb_stall=0, capture all *_mem inputs into the WB register. With wb_stall=1, hold the register.
- FSM states:
  - RUN: if WB holds a valid load and dmem_rvalid=0, then wb_stall=1 (combinational) and the next state is WAIT. If dmem_rvalid=1 in the same cycle, the load completes immediately with zero stall.
  - WAIT: wb_stall=1 until dmem_rvalid=1, then complete this cycle (wb_stall=0), next state RUN. The wait counter increments every WAIT cycle.
  - Timeout: if TIMEOUT>0 and the counter reaches TIMEOUT-1 with no rvalid, complete with load data 0, pulse load_err, return to RUN. The counter clears on leaving WAIT.
- Completion cycle of any valid instruction: retire=1.
  - reg_write_in = reg_write && rd!=0.
  - rd_wb = WB rd.
  - reg_write_data_wb = the source selected by reg_src.
- Combinational output timing:
  - Outputs are combinational from the WB register and dmem inputs; write data is valid in the completion cycle.
  - While stalled: reg_write_in=0, retire=0.
  - rd_wb and reg_write_data_wb still reflect the WB entry.
- Load formatting (offset off = alu_result[1:0]):
  - LB/LBU (000/100): byte at off, sign-/zero-extended.
  - LH/LHU (001/101): halfword at off[1], sign-/zero-extended; off[0] is ignored.
  - LW (010): full word.
  - Other codes: word.
- Edge cases:
  - dmem_rvalid while no load is waiting: ignored.
  - Bubble (valid=0): no write, no retire, no stall.
  - Back-to-back loads each stall independently.
  - Reset asserted in WAIT: abort; nothing is written.

Optional Feature:
- WB_RETIRE_CNT_EN
- Defined: adds output instret (64 bits), reset to 0, incremented by 1 in every cycle retire=1; wraps modulo 2^64.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ALU write: valid, rd=5, reg_src=00, alu=0x1234 -> next cycle reg_write_in=1, rd_wb=5, data=0x1234, retire=1, wb_stall=0.
- rd=0 write: reg_write=1, rd=0, pc_plus4=0x40 -> reg_write_in=0, retire=1.
- Load with latency 3: LB, alu=0x..02, rdata=0x00800000 arriving on the 3rd WB cycle -> wb_stall=1 for 2 cycles, then data=0xFFFFFF80, reg_write_in=1. Upstream inputs held; the next instruction is captured one cycle later.
- LHU/LH, off=2, rdata=0xBEEF0000 -> LHU 0x0000BEEF, LH 0xFFFFBEEF. Zero-latency rvalid -> no stall.
- Timeout, TIMEOUT=4: load, no rvalid -> stall 3 cycles, then data=0, load_err=1, retire=1. A stray rvalid afterward is ignored.
- Reset mid-WAIT: rst_n low for 1 cycle during WAIT -> all outputs 0 immediately, FSM=RUN, no write. With WB_RETIRE_CNT_EN, instret=0 after reset and counts 3 after three retires.
